// File: rtl/spi_flash_defs.sv
// Shared definitions for loading ROM images out of the SPI configuration flash.
// This file holds the flash READ opcode, the loader state encoding, the flash
// offset of each ROM image, and a helper that picks one address byte.
package spi_flash_defs;

    localparam logic [7:0]  SPI_CMD_READ          = 8'h03;

    // Flash offset of each ROM image.
    localparam logic [23:0] BOOT_ROM_FLASH_BASE   = 24'h0A0000;
    localparam logic [23:0] DIVMMC_ROM_FLASH_BASE = 24'h0A4000;

    // Loader state encoding.
    localparam logic [2:0]  ST_IDLE   = 3'd0;
    localparam logic [2:0]  ST_CMD    = 3'd1;
    localparam logic [2:0]  ST_ADDR   = 3'd2;
    localparam logic [2:0]  ST_DATA   = 3'd3;
    localparam logic [2:0]  ST_FINISH = 3'd4;
    localparam logic [2:0]  ST_DONE   = 3'd5;

    // Returns address byte idx, with 0 as the MSB.
    // An idx of 3 returns 0x00, which is the filler byte that follows the address.
    function automatic logic [7:0] header_byte(input logic [23:0] base, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = base[23:16];
            2'd1:    b = base[15:8];
            2'd2:    b = base[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 bit engine: the SCK divider plus the 8-bit transmit and receive shift registers.
// Ports:
//   clk, rst_n     : system clock and asynchronous active-low reset.
//   i_load         : restarts a frame. SCK goes low and i_load_byte becomes the first byte sent.
//   i_load_byte    : the first byte to transmit.
//   i_run          : lets SCK toggle. When it is low the engine idles with SCK=0 and MOSI=0.
//   i_next_byte    : the byte taken in on the falling edge that closes the current byte.
//   i_miso         : serial data input, already synchronised.
//   o_sck, o_mosi  : SPI clock and data out. Both come straight from registers.
//   o_fall         : this clk edge is an SCK falling edge.
//   o_byte_done    : this clk edge is the 8th SCK rising edge of a byte.
//   o_byte_end     : this clk edge is the falling edge that closes a byte.
//   o_rx_byte      : the assembled byte, valid together with o_byte_done.
module spi_byte_shifter #(
    parameter int CLKDIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [7:0] i_load_byte,
    input  logic       i_run,
    input  logic [7:0] i_next_byte,
    input  logic       i_miso,
    output logic       o_sck,
    output logic       o_mosi,
    output logic       o_fall,
    output logic       o_byte_done,
    output logic       o_byte_end,
    output logic [7:0] o_rx_byte
);

    localparam int               DIV_W    = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_sck;
    logic [2:0]       r_bit;
    logic [7:0]       r_tx;
    logic [6:0]       r_rx;
    logic             w_tick;
    logic             w_rise;

    assign w_tick      = i_run && (r_div == DIV_LAST);
    assign w_rise      = w_tick && !r_sck;
    assign o_fall      = w_tick && r_sck;
    assign o_byte_done = w_rise && (r_bit == 3'd7);
    assign o_byte_end  = o_fall && (r_bit == 3'd7);
    // The 8th bit is taken straight from the pin, so the byte is complete on the same edge it arrives.
    assign o_rx_byte   = {r_rx, i_miso};
    assign o_sck       = r_sck;
    assign o_mosi      = r_tx[7];

    // SCK divider, bit counter and shift registers.
    // MOSI changes only on SCK falling edges, so it is stable while SCK is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_sck <= 1'b0;
            r_bit <= 3'd0;
            r_tx  <= 8'h00;
            r_rx  <= 7'h00;
        end else if (i_load) begin
            r_div <= '0;
            r_sck <= 1'b0;
            r_bit <= 3'd0;
            r_tx  <= i_load_byte;
        end else if (!i_run) begin
            r_div <= '0;
            r_sck <= 1'b0;
            r_bit <= 3'd0;
            r_tx  <= 8'h00;
        end else if (w_tick) begin
            r_div <= '0;
            r_sck <= ~r_sck;
            if (w_rise) begin
                r_rx <= o_rx_byte[6:0];
            end else begin
                r_bit <= r_bit + 3'd1;
                r_tx  <= (r_bit == 3'd7) ? i_next_byte : {r_tx[6:0], 1'b0};
            end
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_rom_loader.sv
// Boot-time loader that copies a ROM image from the SPI flash into the ROM BRAM write port.
// The load sends READ (0x03), then FLASH_BASE, then streams BYTES bytes to addresses 0..BYTES-1.
// Ports:
//   clk, rst_n               : system clock and asynchronous active-low reset.
//                              Reset forces the chip select high at once.
//   start                    : single-cycle load request. It is taken only in IDLE or DONE.
//   busy, done               : load in progress, and load completed (held until the next start).
//   flash_cs_n/sck/mosi/miso : SPI mode-0 flash pins.
//   mem_a, mem_dout, mem_we  : ROM write port, with one write strobe per byte.
module spi_rom_loader
    import spi_flash_defs::*;
#(
    parameter logic [23:0] FLASH_BASE = BOOT_ROM_FLASH_BASE,
    parameter int          BYTES      = 9216,
    parameter int          CLKDIV     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        flash_cs_n,
    output logic        flash_sck,
    output logic        flash_mosi,
    input  logic        flash_miso,
    output logic [13:0] mem_a,
    output logic [7:0]  mem_dout,
    output logic        mem_we
);

    localparam logic [14:0] LAST_IDX = 15'(BYTES - 1);

    logic [2:0]  r_state;
    logic        r_start;
    logic        r_busy;
    logic        r_done;
    logic        r_cs_n;
    logic        r_we;
    logic [13:0] r_a;
    logic [7:0]  r_dout;
    logic [14:0] r_idx;
    logic [1:0]  r_hdr;

    logic        w_accept;
    logic        w_run;
    logic [7:0]  w_next_byte;
    logic        w_fall;
    logic        w_byte_done;
    logic        w_byte_end;
    logic [7:0]  w_rx_byte;

    // start is registered first, so the load begins on the edge after it is sampled.
    assign w_accept   = r_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_run      = (r_state == ST_CMD) || (r_state == ST_ADDR) ||
                        (r_state == ST_DATA) || (r_state == ST_FINISH);
    assign busy       = r_busy;
    assign done       = r_done;
    assign flash_cs_n = r_cs_n;
    assign mem_we     = r_we;
    assign mem_a      = r_a;
    assign mem_dout   = r_dout;

    // Selects the byte loaded into the shifter when the current byte finishes.
    always_comb begin
        w_next_byte = 8'h00;
        case (r_state)
            ST_CMD:  w_next_byte = header_byte(FLASH_BASE, 2'd0);
            ST_ADDR: w_next_byte = header_byte(FLASH_BASE, r_hdr + 2'd1);
            default: w_next_byte = 8'h00;
        endcase
    end

    spi_byte_shifter #(
        .CLKDIV (CLKDIV)
    ) u_shifter (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_accept),
        .i_load_byte (SPI_CMD_READ),
        .i_run       (w_run),
        .i_next_byte (w_next_byte),
        .i_miso      (flash_miso),
        .o_sck       (flash_sck),
        .o_mosi      (flash_mosi),
        .o_fall      (w_fall),
        .o_byte_done (w_byte_done),
        .o_byte_end  (w_byte_end),
        .o_rx_byte   (w_rx_byte)
    );

    // Load sequencer, byte counter and ROM write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_we    <= 1'b0;
            r_a     <= 14'd0;
            r_dout  <= 8'h00;
            r_idx   <= 15'd0;
            r_hdr   <= 2'd0;
        end else begin
            r_start <= start;
            r_we    <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_state <= ST_CMD;
                        r_cs_n  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_idx   <= 15'd0;
                        r_hdr   <= 2'd0;
                    end
                end
                ST_CMD: begin
                    if (w_byte_end) begin
                        r_state <= ST_ADDR;
                        r_hdr   <= 2'd0;
                    end
                end
                ST_ADDR: begin
                    if (w_byte_end) begin
                        if (r_hdr == 2'd2) begin
                            r_state <= ST_DATA;
                        end else begin
                            r_hdr <= r_hdr + 2'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_byte_done) begin
                        r_we   <= 1'b1;
                        r_a    <= r_idx[13:0];
                        r_dout <= w_rx_byte;
                        if (r_idx == LAST_IDX) begin
                            r_state <= ST_FINISH;
                        end else begin
                            r_idx <= r_idx + 15'd1;
                        end
                    end
                end
                ST_FINISH: begin
                    // The last byte is already written. The transaction closes on the final SCK fall.
                    if (w_fall) begin
                        r_state <= ST_DONE;
                        r_cs_n  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cs_n  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_rom_loader.sv
module tb_spi_rom_loader;

    logic        clk = 1'b0;
    logic [2:0]  rst_v;
    logic [2:0]  start_v;
    logic [2:0]  busy_v, done_v, cs_v, sck_v, mosi_v, we_v, miso_v;
    logic [13:0] a_v [3];
    logic [7:0]  d_v [3];
    logic [31:0] cmd_v [3];

    int n_chk  = 0;
    int n_pass = 0;
    int sel    = 0;

    logic        v_busy, v_done, v_cs, v_sck, v_mosi, v_we;
    logic [13:0] v_a;
    logic [7:0]  v_d;

    always #5 clk = ~clk;

    // u_a: CLKDIV=1, BYTES=4.  u_b: CLKDIV=3, BYTES=4.  u_c: CLKDIV=1, BYTES=1.
    spi_rom_loader #(.FLASH_BASE(24'h0A0000), .BYTES(4), .CLKDIV(1)) u_a (
        .clk(clk), .rst_n(rst_v[0]), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .flash_cs_n(cs_v[0]), .flash_sck(sck_v[0]), .flash_mosi(mosi_v[0]), .flash_miso(miso_v[0]),
        .mem_a(a_v[0]), .mem_dout(d_v[0]), .mem_we(we_v[0]));
    spi_rom_loader #(.FLASH_BASE(24'h0A0000), .BYTES(4), .CLKDIV(3)) u_b (
        .clk(clk), .rst_n(rst_v[1]), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .flash_cs_n(cs_v[1]), .flash_sck(sck_v[1]), .flash_mosi(mosi_v[1]), .flash_miso(miso_v[1]),
        .mem_a(a_v[1]), .mem_dout(d_v[1]), .mem_we(we_v[1]));
    spi_rom_loader #(.FLASH_BASE(24'h0A0000), .BYTES(1), .CLKDIV(1)) u_c (
        .clk(clk), .rst_n(rst_v[2]), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .flash_cs_n(cs_v[2]), .flash_sck(sck_v[2]), .flash_mosi(mosi_v[2]), .flash_miso(miso_v[2]),
        .mem_a(a_v[2]), .mem_dout(d_v[2]), .mem_we(we_v[2]));

    assign v_busy = busy_v[sel];
    assign v_done = done_v[sel];
    assign v_cs   = cs_v[sel];
    assign v_sck  = sck_v[sel];
    assign v_mosi = mosi_v[sel];
    assign v_we   = we_v[sel];
    assign v_a    = a_v[sel];
    assign v_d    = d_v[sel];

    // Flash data: bit k of the transaction (k counts SCK falls since CS low).
    // Data byte j is 0x11*(j+1) for j = 0..3.
    function automatic logic flash_bit(input int unsigned k);
        int unsigned d;
        logic [7:0]  b;
        if (k < 32) return 1'b0;
        d = k - 32;
        if (d / 8 >= 4) return 1'b0;
        b = 8'(8'h11 * (d / 8 + 1));
        return b[7 - (d % 8)];
    endfunction

    for (genvar g = 0; g < 3; g++) begin : fl
        int unsigned k   = 0;
        logic [31:0] cap = 32'h0;
        // Count SCK falls in the transaction, and restart the count whenever CS goes high.
        always @(negedge sck_v[g] or posedge cs_v[g]) begin
            if (cs_v[g]) k <= 0;
            else         k <= k + 1;
        end
        // Capture the first 32 MOSI bits (command and address) on SCK rising edges.
        always @(posedge sck_v[g]) begin
            if (k < 32) cap <= {cap[30:0], mosi_v[g]};
        end
        assign miso_v[g] = flash_bit(k);
        assign cmd_v[g]  = cap;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    endtask

    // Pulse start on DUT s, then follow one load until done (bounded).
    // The check covers write addresses and data, latency, command bytes and SCK phase length.
    // With poke set, a second start is pulsed while the load is busy.
    task automatic run_load(input int s, input int nbytes, input int lat, input int clkdiv, input bit poke);
        int         c, wi, done_c, bad_runs, run_len;
        logic       prev_sck;
        logic [7:0] expd;
        sel = s;
        @(negedge clk); start_v[s] = 1'b1;
        @(negedge clk); start_v[s] = 1'b0;
        c = 0; wi = 0; done_c = -1; bad_runs = 0; run_len = 0; prev_sck = 1'b0;
        while (done_c < 0 && c < lat + 40) begin
            @(negedge clk);
            c++;
            start_v[s] = (poke && c == 20) ? 1'b1 : 1'b0;
            if (c == 1) begin
                chk("t1_cs_n", 32'(v_cs), 32'd0);
                chk("t1_busy", 32'(v_busy), 32'd1);
                chk("t1_done", 32'(v_done), 32'd0);
            end
            if (!v_cs) begin
                if (v_sck == prev_sck) begin
                    run_len++;
                end else begin
                    if (run_len != clkdiv) bad_runs++;
                    run_len = 1;
                end
                prev_sck = v_sck;
            end
            if (v_we) begin
                expd = 8'(8'h11 * (wi + 1));
                chk("we_addr", 32'(v_a), 32'(wi));
                chk("we_data", 32'(v_d), 32'(expd));
                wi++;
            end
            if (v_done) done_c = c;
        end
        chk("done_latency", 32'(done_c), 32'(lat));
        chk("write_count", 32'(wi), 32'(nbytes));
        chk("cmd_addr_bits", cmd_v[s], 32'h030A0000);
        chk("sck_phase_runs", 32'(bad_runs), 32'd0);
        chk("end_busy", 32'(v_busy), 32'd0);
        chk("end_cs_n", 32'(v_cs), 32'd1);
    endtask

    initial begin
        int c, nwe;
        rst_v   = 3'b000;
        start_v = 3'b000;
        sel     = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(v_busy), 32'd0);
        chk("rst_done", 32'(v_done), 32'd0);
        chk("rst_cs_n", 32'(v_cs), 32'd1);
        chk("rst_sck", 32'(v_sck), 32'd0);
        chk("rst_mosi", 32'(v_mosi), 32'd0);
        chk("rst_we", 32'(v_we), 32'd0);
        chk("rst_a", 32'(v_a), 32'd0);
        chk("rst_dout", 32'(v_d), 32'd0);
        rst_v = 3'b111;
        @(negedge clk);

        // Basic load: latency is 1 + 2*1*64 = 129 cycles.
        run_load(0, 4, 129, 1, 1'b0);
        repeat (5) @(negedge clk);
        chk("done_held", 32'(v_done), 32'd1);
        chk("idle_sck", 32'(v_sck), 32'd0);
        // Start while in DONE: done drops at T0+1 and the same latency follows.
        run_load(0, 4, 129, 1, 1'b0);
        // A start pulsed while busy has no effect.
        run_load(0, 4, 129, 1, 1'b1);

        // Reset during the second data byte (cycles T0+82..T0+97 for CLKDIV=1).
        sel = 0;
        @(negedge clk); start_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0;
        nwe = 0;
        for (c = 1; c <= 85; c++) begin
            @(negedge clk);
            if (v_we) nwe++;
        end
        chk("pre_rst_writes", 32'(nwe), 32'd1);
        chk("pre_rst_cs_n", 32'(v_cs), 32'd0);
        rst_v[0] = 1'b0;
        #1;
        chk("arst_cs_n", 32'(v_cs), 32'd1);
        chk("arst_sck", 32'(v_sck), 32'd0);
        chk("arst_busy", 32'(v_busy), 32'd0);
        chk("arst_done", 32'(v_done), 32'd0);
        nwe = 0;
        repeat (6) begin
            @(negedge clk);
            if (v_we) nwe++;
        end
        chk("rst_no_we", 32'(nwe), 32'd0);
        rst_v[0] = 1'b1;
        run_load(0, 4, 129, 1, 1'b0);

        // CLKDIV=3: latency is 1 + 2*3*64 = 385 cycles, and every SCK phase lasts 3 cycles.
        run_load(1, 4, 385, 3, 1'b0);
        // BYTES=1: N = 40 bits, so latency is 1 + 2*40 = 81 cycles.
        run_load(2, 1, 81, 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_rom_loader.md
# spi_rom_loader

Boot-time sequencer that fills the boot/DivMMC ROM BRAM from the SPI configuration flash instead of from synthesis-time hex images. On `start` it issues one SPI READ (0x03) command at a fixed flash offset, streams `BYTES` bytes, and writes each one into the ROM's write port at consecutive addresses from 0. It sits between the flash pins and the ROM memory array. `busy` holds the CPU in reset/wait until `done` rises.

## Interface
Parameters:
- `FLASH_BASE`, 24'h0A0000: byte offset in flash of the ROM image.
- `BYTES`, 9216: number of bytes to copy; range 1..16384.
- `CLKDIV`, 2: `clk` cycles per SCK half-period; must be ≥1. SCK = clk/(2·CLKDIV).

Ports:
- `clk`, input, 1: system clock; the only clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: single-cycle request to begin a load.
- `busy`, output, 1: high from the cycle after an accepted `start` until `done`.
- `done`, output, 1: high after a completed load; held until the next accepted `start` or reset.
- `flash_cs_n`, output, 1: flash chip select.
- `flash_sck`, output, 1: SPI clock, mode 0, idles low.
- `flash_mosi`, output, 1: serial data to flash, MSB first.
- `flash_miso`, input, 1: serial data from flash; pre-synchronised by the pad logic.
- `mem_a`, output, 14: ROM write address.
- `mem_dout`, output, 8: ROM write data.
- `mem_we`, output, 1: ROM write strobe, one `clk` wide per byte.

## Operation
- Reset values: `busy`=0, `done`=0, `flash_cs_n`=1, `flash_sck`=0, `flash_mosi`=0, `mem_we`=0, `mem_a`=0, `mem_dout`=0.
- States and transitions:
  - IDLE → CMD on `start`.
  - CMD: 8 bits of 0x03 → ADDR.
  - ADDR: 24 bits of `FLASH_BASE` → DATA.
  - DATA: `BYTES`×8 bits → FINISH.
  - FINISH → DONE.
  - DONE → CMD on `start`.
- `start` is accepted only in IDLE or DONE. It is ignored while `busy`.
- Mode 0 protocol:
  - MOSI changes only while SCK is low.
  - MISO is sampled on the internal SCK rising edge, into an 8-bit shift register, MSB first.
  - During DATA, `flash_mosi` is driven 0.
- Byte counter is 15 bits and counts up to `BYTES`. `mem_a` equals the byte index, truncated to 14 bits.
- Per data byte, the cycle after its 8th rising SCK edge:
  - `mem_we`=1;
  - `mem_dout`= the assembled byte;
  - `mem_a`= the index.
- `mem_a`/`mem_dout` hold their last values when `mem_we`=0.
- After the last byte, FINISH waits for the final SCK fall.
- Reset mid-load: the block returns to IDLE immediately, with the reset values above.
  - `flash_cs_n` is asynchronously forced high, ending the flash transaction.
  - ROM contents already written remain; no retry.
- A `start` in DONE clears `done` and reloads from byte 0.

## Timing
- Let `start` be sampled high at edge T0 (IDLE/DONE).
- At T0+1:
  - `flash_cs_n`=0;
  - `busy`=1;
  - `done`=0;
  - `flash_mosi`= command bit 7.
- SCK edges for bit k (k=0..N−1, N=32+8·BYTES):
  - rising at T0+1+CLKDIV·(2k+1);
  - falling at T0+1+CLKDIV·(2k+2).
- MOSI for bit k+1 is updated on the same edge as the falling edge of bit k.
- `mem_we` for data byte j is high for exactly the one cycle after the rising edge of bit 32+8j+7.
- At the final falling edge T0+1+2·CLKDIV·N:
  - `flash_cs_n`=1, `busy`=0, `done`=1, all on the same edge.
- Total load latency is 2·CLKDIV·N+1 cycles.

## Structure
- Shared package/header `spi_flash_defs`:
  - `SPI_CMD_READ`=8'h03;
  - state encoding constants;
  - default `FLASH_BASE` for each ROM image.
- One natural sub-module: `spi_byte_shifter`.
  - Contains the SCK divider, the 8-bit TX/RX shift registers and a `byte_done` pulse.
  - The top module holds the FSM, the address/byte counters and the ROM write port.

## Test plan
- CLKDIV=1, BYTES=4, FLASH_BASE=24'h0A0000, flash model returns 0x11,0x22,0x33,0x44.
  - Required: MOSI carries 0x03,0x0A,0x00,0x00.
  - Required: four `mem_we` pulses at a=0..3 with data 0x11..0x44.
  - Required: `done` at T0+1+2·64.
- CLKDIV=3: SCK high/low phases are each exactly 3 cycles; the data bytes written are the same.
- `start` pulsed while `busy`: no effect; write count and timing are identical to a single start.
- `rst_n` low during the 2nd data byte:
  - `flash_cs_n`=1 and `flash_sck`=0 asynchronously;
  - no further `mem_we`;
  - `busy`=0, `done`=0.
  - A subsequent `start` completes a full load from a=0.
- `start` in DONE:
  - `done` falls at T0+1;
  - the second load rewrites a=0..3;
  - `done` rises again after the same latency.
- BYTES=16384: last write at a=16383, and `mem_a` never wraps before `done`.
